// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit -- instruction fetch front end.
//
// Issues sequential word fetches to an in-order instruction memory and
// buffers the returned words in a small FIFO that feeds decode. Requests are
// credit limited, so every response has a free queue slot waiting for it.
// A redirect flushes the queue, retargets the fetch PC and discards every
// response still in flight from before the redirect.
//
// Optional feature (macro FETCH_MISALIGN_TRAP_EN): a redirect to a target
// that is not word aligned halts fetch and raises fetch_fault until the next
// aligned redirect. Without the macro the low target bits are ignored and
// fetch_fault is constant 0.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   QDEPTH    instruction queue depth (power of two, 2..8)
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        fetch request channel
//   imem_rsp_valid/data              in-order fetch responses
//   redirect_valid, redirect_pc      branch/jump redirect
//   id_valid/ready, id_instr, id_pc  instruction handed to decode
//   id_key                           {instr[30], instr[14:12], instr[6:0]}
//   fetch_fault                      misaligned-redirect fault
module rv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [10:0] id_key,
  output logic        fetch_fault
);

  localparam int          PW = $clog2(QDEPTH);
  localparam int          CW = PW + 1;
  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;          // next address to request
  logic [31:0]   tag_pc_q, tag_pc_d;  // address of the next kept response
  logic [CW-1:0] out_q, out_d;        // accepted requests not yet answered
  logic [CW-1:0] disc_q, disc_d;      // of those, how many are stale
  logic [CW-1:0] cnt_q, cnt_d;        // queue occupancy
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [31:0]   qinstr_q [QDEPTH];
  logic [31:0]   qpc_q    [QDEPTH];

  logic          req_fire;
  logic          pop;
  logic          push;
  logic          redir_fault;
  logic [31:0]   redir_tgt;
  logic [CW:0]   credit_used;

  assign redir_tgt = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;

  assign redir_fault = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      fault_q <= redir_fault;
    end
  end

  assign fetch_fault = fault_q;
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redir_fault          = 1'b0;
  assign fetch_fault          = 1'b0;
`endif

  // Stale in-flight requests still hold credit: their responses will arrive
  // and must be absorbed before the credit can be reused.
  assign credit_used    = {1'b0, out_q} + {1'b0, cnt_q};
  // Gated by rst_n so the request is low while reset is held.
  assign imem_req_valid = rst_n && (state_q == RUN) && !redirect_valid
                          && (credit_used < QD);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign id_valid = (cnt_q != '0) && (state_q == RUN);
  assign id_instr = id_valid ? qinstr_q[rd_q] : 32'h0;
  assign id_pc    = id_valid ? qpc_q[rd_q]    : 32'h0;
  assign id_key   = {id_instr[30], id_instr[14:12], id_instr[6:0]};
  assign pop      = id_valid && id_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tag_pc_d = tag_pc_q;
    out_d    = out_q;
    disc_d   = disc_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    push     = 1'b0;
    if (redirect_valid) begin
      // A response landing this cycle is dropped; everything still in
      // flight afterwards belongs to the old path and is marked stale.
      pc_d     = redir_tgt;
      tag_pc_d = redir_tgt;
      out_d    = out_q - CW'(imem_rsp_valid);
      disc_d   = out_d;
      cnt_d    = '0;
      rd_d     = wr_q;
      state_d  = redir_fault ? HALT : RUN;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rsp_valid) begin
        if (disc_q != '0) begin
          disc_d = disc_q - CW'(1);
        end else begin
          push = 1'b1;
        end
      end
      out_d = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (push) begin
        wr_d     = wr_q + PW'(1);
        tag_pc_d = tag_pc_q + 32'd4;
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      tag_pc_q <= RESET_PC;
      out_q    <= '0;
      disc_q   <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tag_pc_q <= tag_pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  // Queue storage carries data only; validity lives in cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      qinstr_q[wr_q] <= imem_rsp_data;
      qpc_q[wr_q]    <= tag_pc_q;
    end
  end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Testbench for rv_fetch_unit: randomized memory/decode/redirect traffic
// checked every cycle against a transaction-level model (memory in-flight
// list tagged with a redirect epoch, plus a queue of kept instruction PCs),
// followed by literal checks for the directed scenarios.
module tb_rv_fetch_unit;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [63:0] XX       = 'x;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [10:0] id_key;
  logic        fetch_fault;

  always #5 clk = ~clk;

  rv_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_key(id_key), .fetch_fault(fetch_fault)
  );

  typedef struct { logic [31:0] addr; int ep; int due; } mreq_t;

  mreq_t       mem_q[$];   // memory: accepted requests awaiting response
  logic [31:0] mq[$];      // model: PCs of instructions decode must see
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  int          req_cyc[$];
  int          pop_cyc[$];
  logic [10:0] key40;
  bit          key40_seen = 0;
  int          cyc = 0, cur_ep = 0, checks = 0, errors = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          halted = 0, exp_fault = 0;
  int          rdy_pct, mrdy_pct, rsp_pct, lat_min, lat_max, redir_permil;
  int          n, rb, pb;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    if (a == 32'h40) return 32'h40B5_0533;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [10:0] key_of(input logic [31:0] w);
    return 11'((((w >> 30) & 32'h1) << 10) | (((w >> 12) & 32'h7) << 7)
               | (w & 32'h7F));
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom_range(0, 32'hFFF);
    if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  function automatic logic [63:0] rq(input int i);
    return (i < req_log.size()) ? 64'(req_log[i]) : XX;
  endfunction
  function automatic logic [63:0] pq(input int i);
    return (i < pop_log.size()) ? 64'(pop_log[i]) : XX;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model by the
  // handshakes that will complete at the coming rising edge.
  always @(negedge clk) begin : model
    bit          ev_req, ev_id, fire, pop, have_rsp;
    mreq_t       ent;
    logic [31:0] w;
    if (!rst_n) begin
      mem_q.delete();
      mq.delete();
      cur_ep++;
      exp_pc    = RESET_PC;
      halted    = 0;
      exp_fault = 0;
      chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
      chk("rst_id_valid", 64'(id_valid), 64'(0));
      chk("rst_fetch_fault", 64'(fetch_fault), 64'(0));
    end else begin
      ev_req = !halted && !redirect_valid && ((mem_q.size() + mq.size()) < QDEPTH);
      chk("req_valid", 64'(imem_req_valid), 64'(ev_req));
      if (ev_req) chk("req_addr", 64'(imem_req_addr), 64'(exp_pc));
      ev_id = (mq.size() != 0);
      chk("id_valid", 64'(id_valid), 64'(ev_id));
      if (ev_id) begin
        w = memdata(mq[0]);
        chk("id_pc", 64'(id_pc), 64'(mq[0]));
        chk("id_instr", 64'(id_instr), 64'(w));
        chk("id_key", 64'(id_key), 64'(key_of(w)));
      end
      chk("fetch_fault", 64'(fetch_fault), 64'(exp_fault));
      fire = ev_req && imem_req_ready;
      pop  = ev_id && id_ready;
      if (fire) begin
        req_log.push_back(exp_pc);
        req_cyc.push_back(cyc);
      end
      if (pop) begin
        pop_log.push_back(mq[0]);
        pop_cyc.push_back(cyc);
        if (mq[0] == 32'h40) begin
          key40      = id_key;
          key40_seen = 1;
        end
      end
      have_rsp = 0;
      if (imem_rsp_valid && mem_q.size() != 0) begin
        ent      = mem_q.pop_front();
        have_rsp = 1;
      end
      if (redirect_valid) begin
        mq.delete();
        cur_ep++;
        exp_pc = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
        halted = (redirect_pc[1:0] != 2'b00);
`else
        halted = 0;
`endif
        exp_fault = halted;
      end else begin
        if (pop) void'(mq.pop_front());
        if (have_rsp && ent.ep == cur_ep) mq.push_back(ent.addr);
        if (fire) begin
          mem_q.push_back('{exp_pc, cur_ep,
                            cyc + 1 + int'($urandom_range(lat_max, lat_min))});
          exp_pc += 32'd4;
        end
      end
    end
  end

  task automatic drive();
    id_ready       = ($urandom_range(0, 99) < rdy_pct);
    imem_req_ready = ($urandom_range(0, 99) < mrdy_pct);
    if (rst_n && mem_q.size() != 0 && mem_q[0].due <= cyc
        && $urandom_range(0, 99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memdata(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if ($urandom_range(0, 999) < redir_permil) begin
      redirect_valid = 1'b1;
      redirect_pc    = rand_target();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    rdy_pct = 100; mrdy_pct = 100; rsp_pct = 100;
    lat_min = 0; lat_max = 0; redir_permil = 0;
    repeat (3) @(posedge clk);

    // Streaming after reset with a 1-cycle memory and decode always ready.
    @(posedge clk); #1; rst_n = 1'b1; drive();
    rb = req_log.size(); pb = pop_log.size();
    n = 0;
    while (!key40_seen && n < 60) begin step(); n++; end
    chk("stream_req0", rq(rb), 64'h0);
    chk("stream_req1", rq(rb + 1), 64'h4);
    chk("stream_req2", rq(rb + 2), 64'h8);
    chk("stream_req_b2b", (req_cyc.size() > rb + 2) ? 64'(req_cyc[rb + 2] - req_cyc[rb]) : XX, 64'd2);
    chk("stream_id0", pq(pb), 64'h0);
    chk("stream_id1", pq(pb + 1), 64'h4);
    chk("stream_id2", pq(pb + 2), 64'h8);
    chk("stream_no_bubble", (pop_cyc.size() > pb + 16) ? 64'(pop_cyc[pb + 16] - pop_cyc[pb]) : XX, 64'd16);
    chk("sub_key", key40_seen ? 64'(key40) : XX, 64'(11'b1_000_0110011));

    // Decode stalled from reset: only QDEPTH requests, head held at 0x0.
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rdy_pct = 0; rst_n = 1'b1; drive();
    rb = req_log.size(); pb = pop_log.size();
    repeat (10) step();
    chk("stall_req_count", 64'(req_log.size() - rb), 64'(QDEPTH));
    chk("stall_no_pop", 64'(pop_log.size() - pb), 64'd0);
    chk("stall_id_valid", 64'(id_valid), 64'd1);
    chk("stall_id_pc", 64'(id_pc), 64'h0);

    // Redirect with responses outstanding.
    rdy_pct = 100; lat_min = 3; lat_max = 3;
    n = 0;
    while (mem_q.size() < 2 && n < 40) begin step(); n++; end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk); #1;
    pb = pop_log.size();
    n = 0;
    while (pop_log.size() == pb && n < 40) begin step(); n++; end
    chk("redirect_first_pc", pq(pb), 64'h100);

    // Misaligned redirect target.
    step(); redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk); #1;
    rb = req_log.size();
`ifdef FETCH_MISALIGN_TRAP_EN
    repeat (6) step();
    chk("misalign_fault", 64'(fetch_fault), 64'd1);
    chk("misalign_no_req", 64'(req_log.size() - rb), 64'd0);
    chk("misalign_no_id", 64'(id_valid), 64'd0);
    step(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk); #1;
    rb = req_log.size();
    step();
    chk("realign_fault_clear", 64'(fetch_fault), 64'd0);
    n = 0;
    while (req_log.size() == rb && n < 20) begin step(); n++; end
    chk("realign_first_req", rq(rb), 64'h200);
`else
    n = 0;
    while (req_log.size() == rb && n < 20) begin step(); n++; end
    chk("misalign_lsbs_ignored", rq(rb), 64'h100);
    chk("misalign_no_fault", 64'(fetch_fault), 64'd0);
`endif

    // Randomized traffic.
    rdy_pct = 70; mrdy_pct = 70; rsp_pct = 75; lat_min = 0; lat_max = 3;
    redir_permil = 25;
    repeat (3000) step();

    // Asynchronous reset with a response pending.
    redir_permil = 0; rdy_pct = 100; mrdy_pct = 100; rsp_pct = 100;
    lat_min = 3; lat_max = 3;
    step(); redirect_valid = 1'b1; redirect_pc = 32'h300;
    n = 0;
    while ((mem_q.size() == 0 || !id_valid) && n < 40) begin step(); n++; end
    #2; rst_n = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    chk("async_req_valid", 64'(imem_req_valid), 64'd0);
    chk("async_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
    chk("async_id_valid", 64'(id_valid), 64'd0);
    chk("async_id_pc", 64'(id_pc), 64'd0);
    chk("async_id_instr", 64'(id_instr), 64'd0);
    chk("async_id_key", 64'(id_key), 64'd0);
    chk("async_fetch_fault", 64'(fetch_fault), 64'd0);
    repeat (2) step();
    @(posedge clk); #1; rst_n = 1'b1; drive();
    rb = req_log.size(); pb = pop_log.size();
    n = 0;
    while (pop_log.size() == pb && n < 20) begin step(); n++; end
    chk("post_reset_first_req", rq(rb), 64'(RESET_PC));
    chk("post_reset_first_id", pq(pb), 64'(RESET_PC));
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
